// File: rtl/exec_sequencer.sv
// Run-control sequencer: fetch/execute phase, run/halt/step control and one PC breakpoint.
// Define INSTR_COUNT_EN to build the retired-instruction counter; otherwise instr_count reads 0.
module exec_sequencer #(
    parameter int unsigned       ADDR_W       = 12,
    parameter int unsigned       MISC_W       = 6,
    parameter logic [MISC_W-1:0] MISC_WR_MASK = 6'b000011,
    parameter bit                START_RUN    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic              dec_incPC,
    input  logic              dec_loadPC,
    input  logic              dec_loadA,
    input  logic              dec_loadFlags,
    input  logic [2:0]        dec_aluopcode,
    input  logic [MISC_W-1:0] dec_misc,
    output logic              phase,
    output logic              incPC,
    output logic              loadPC,
    output logic              loadA,
    output logic              loadFlags,
    output logic [2:0]        aluopcode,
    output logic [MISC_W-1:0] misc,
    output logic              running,
    output logic              bp_hit,
    output logic [15:0]       instr_count
);

    typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP} state_e;

    state_e state_q, state_d;
    logic   phase_q, phase_d;
    logic   bp_hit_q, bp_hit_d;
    logic   skip_q, skip_d;
    logic   pend_q, pend_d;
    logic   bp_fire;
    logic   exec_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= START_RUN ? ST_RUN : ST_HALT;
            phase_q  <= 1'b1;
            bp_hit_q <= 1'b0;
            skip_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bp_hit_q <= bp_hit_d;
            skip_q   <= skip_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bp_hit_d = bp_hit_q;
        skip_d   = skip_q;
        pend_d   = pend_q;
        bp_fire  = bp_en && (pc == bp_addr) && phase_q && (state_q == ST_RUN) && !skip_q;
        case (state_q)
            ST_HALT: begin
                pend_d = 1'b0;
                // halt_req outranks both resume requests, step outranks run
                if (!halt_req) begin
                    if (step_req) begin
                        state_d = ST_STEP;
                        skip_d  = 1'b1;
                    end else if (run_req) begin
                        state_d  = ST_RUN;
                        skip_d   = 1'b1;
                        bp_hit_d = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (bp_fire) begin
                    state_d  = ST_HALT;
                    bp_hit_d = 1'b1;
                    pend_d   = 1'b0;
                end else begin
                    phase_d = !phase_q;
                    if (phase_q) begin
                        skip_d = 1'b0;
                        if (halt_req) pend_d = 1'b1;
                    end else if (halt_req || pend_q) begin
                        state_d = ST_HALT;
                        pend_d  = 1'b0;
                    end
                end
            end
            ST_STEP: begin
                phase_d = !phase_q;
                if (phase_q) begin
                    skip_d = 1'b0;
                end else begin
                    state_d = ST_HALT;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // reset gates the strobes directly so they drop without waiting for a clock
    assign exec_en   = reset && (state_q != ST_HALT) && !bp_fire;
    assign running   = (state_q != ST_HALT);
    assign phase     = phase_q;
    assign bp_hit    = bp_hit_q;
    assign incPC     = dec_incPC && exec_en;
    assign loadPC    = dec_loadPC && exec_en;
    assign loadA     = dec_loadA && exec_en;
    assign loadFlags = dec_loadFlags && exec_en;
    assign aluopcode = dec_aluopcode;
    assign misc      = exec_en ? dec_misc : (dec_misc & ~MISC_WR_MASK);

`ifdef INSTR_COUNT_EN
    logic [15:0] cnt_q;
    logic        boundary;

    assign boundary = (state_q != ST_HALT) && !phase_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        cnt_q <= '0;
        else if (boundary) cnt_q <= cnt_q + 16'd1;
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized scoreboard bench for exec_sequencer: two instances (START_RUN=0 and 1) share stimulus.
module tb_exec_sequencer;

    localparam int NCYC = 1600;
    localparam int M_HALTED = 0;
    localparam int M_FREE   = 1;
    localparam int M_SINGLE = 2;

    typedef struct packed {
        logic        phase, inc, ldpc, lda, ldf;
        logic [2:0]  alu;
        logic [5:0]  misc;
        logic        running, bp_hit;
        logic [15:0] cnt;
    } out_t;

    typedef struct packed {
        out_t e0;
        out_t e1;
    } exp_t;

    typedef struct {
        int          mode;
        bit          fetch;
        bit          halt_after;
        bit          guard;
        bit          bp_flag;
        int unsigned retired;
    } mdl_t;

    typedef struct {
        bit        rst_n, run, halt, step, bp_en;
        bit [11:0] bp_addr, pc;
        bit        inc, ldpc, lda, ldf;
        bit [2:0]  alu;
        bit [5:0]  misc;
    } in_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_req, halt_req, step_req, bp_en;
    logic [11:0] bp_addr, pc;
    logic        dec_incPC, dec_loadPC, dec_loadA, dec_loadFlags;
    logic [2:0]  dec_aluopcode;
    logic [5:0]  dec_misc;

    logic        phase0, inc0, ldpc0, lda0, ldf0, run0, bph0;
    logic [2:0]  alu0;
    logic [5:0]  misc0;
    logic [15:0] cnt0;
    logic        phase1, inc1, ldpc1, lda1, ldf1, run1, bph1;
    logic [2:0]  alu1;
    logic [5:0]  misc1;
    logic [15:0] cnt1;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    exec_sequencer #(.START_RUN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .dec_incPC(dec_incPC), .dec_loadPC(dec_loadPC), .dec_loadA(dec_loadA),
        .dec_loadFlags(dec_loadFlags), .dec_aluopcode(dec_aluopcode), .dec_misc(dec_misc),
        .phase(phase0), .incPC(inc0), .loadPC(ldpc0), .loadA(lda0), .loadFlags(ldf0),
        .aluopcode(alu0), .misc(misc0), .running(run0), .bp_hit(bph0), .instr_count(cnt0)
    );

    exec_sequencer #(.START_RUN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .dec_incPC(dec_incPC), .dec_loadPC(dec_loadPC), .dec_loadA(dec_loadA),
        .dec_loadFlags(dec_loadFlags), .dec_aluopcode(dec_aluopcode), .dec_misc(dec_misc),
        .phase(phase1), .incPC(inc1), .loadPC(ldpc1), .loadA(lda1), .loadFlags(ldf1),
        .aluopcode(alu1), .misc(misc1), .running(run1), .bp_hit(bph1), .instr_count(cnt1)
    );

    function automatic mdl_t model_reset(bit start_run);
        mdl_t m;
        m.mode       = start_run ? M_FREE : M_HALTED;
        m.fetch      = 1'b1;
        m.halt_after = 1'b0;
        m.guard      = 1'b0;
        m.bp_flag    = 1'b0;
        m.retired    = 0;
        return m;
    endfunction

    function automatic bit model_trap(mdl_t m, in_t i);
        return m.mode == M_FREE && m.fetch && i.bp_en && i.pc == i.bp_addr && !m.guard;
    endfunction

    function automatic out_t model_out(mdl_t m, in_t i);
        out_t o;
        bit   pass;
        pass      = i.rst_n && m.mode != M_HALTED && !model_trap(m, i);
        o.phase   = m.fetch;
        o.inc     = pass & i.inc;
        o.ldpc    = pass & i.ldpc;
        o.lda     = pass & i.lda;
        o.ldf     = pass & i.ldf;
        o.alu     = i.alu;
        o.misc    = pass ? i.misc : (i.misc & 6'b111100);
        o.running = m.mode != M_HALTED;
        o.bp_hit  = m.bp_flag;
`ifdef INSTR_COUNT_EN
        o.cnt     = m.retired[15:0];
`else
        o.cnt     = 16'h0000;
`endif
        return o;
    endfunction

    function automatic mdl_t model_next(mdl_t m, in_t i, bit start_run);
        mdl_t n;
        n = m;
        if (!i.rst_n) return model_reset(start_run);
        if (m.mode == M_HALTED) begin
            if (i.halt) begin
                // highest priority request: remain halted
            end else if (i.step) begin
                n.mode  = M_SINGLE;
                n.guard = 1'b1;
            end else if (i.run) begin
                n.mode    = M_FREE;
                n.guard   = 1'b1;
                n.bp_flag = 1'b0;
            end
        end else if (model_trap(m, i)) begin
            n.mode       = M_HALTED;
            n.bp_flag    = 1'b1;
            n.halt_after = 1'b0;
        end else if (m.fetch) begin
            n.guard = 1'b0;
            n.fetch = 1'b0;
            if (i.halt && m.mode == M_FREE) n.halt_after = 1'b1;
        end else begin
            n.retired = m.retired + 1;
            n.fetch   = 1'b1;
            if (m.mode == M_SINGLE || m.halt_after || i.halt) begin
                n.mode       = M_HALTED;
                n.halt_after = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic apply(in_t i);
        reset         = i.rst_n;
        run_req       = i.run;
        halt_req      = i.halt;
        step_req      = i.step;
        bp_en         = i.bp_en;
        bp_addr       = i.bp_addr;
        pc            = i.pc;
        dec_incPC     = i.inc;
        dec_loadPC    = i.ldpc;
        dec_loadA     = i.lda;
        dec_loadFlags = i.ldf;
        dec_aluopcode = i.alu;
        dec_misc      = i.misc;
    endtask

    // {rst_n, run, halt, step} for the opening cycles, random afterwards
    logic [3:0] prefix [0:39] = '{
        4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1010,
        4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b1111,
        4'b1000, 4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b1000, 4'b1000,
        4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000,
        4'b1100, 4'b1000, 4'b1000, 4'b1010, 4'b1000, 4'b1000, 4'b1001, 4'b1000
    };

    task automatic stimulus();
        mdl_t m0, m1;
        in_t  i;
        exp_t e;
        logic [3:0] p;
        m0 = model_reset(1'b0);
        m1 = model_reset(1'b1);
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            if (c < 40) begin
                p      = prefix[c];
                i.rst_n = p[3];
                i.run   = p[2];
                i.halt  = p[1];
                i.step  = p[0];
            end else begin
                i.rst_n = ($urandom_range(0, 299) != 0);
                i.run   = ($urandom_range(0, 9) == 0);
                i.halt  = ($urandom_range(0, 11) == 0);
                i.step  = ($urandom_range(0, 9) == 0);
            end
            i.bp_en   = (c < 40) ? 1'b1 : ((c / 64) % 3 != 0);
            i.bp_addr = (c % 200 < 150) ? 12'h00A : 12'($urandom_range(0, 15));
            i.pc      = (c < 40) ? 12'(c % 16) : 12'($urandom_range(0, 15));
            i.inc     = 1'($urandom);
            i.ldpc    = 1'($urandom);
            i.lda     = (c % 7 == 0) ? 1'b1 : 1'($urandom);
            i.ldf     = 1'($urandom);
            i.alu     = 3'($urandom);
            i.misc    = 6'($urandom);
            apply(i);
            if (!i.rst_n) begin
                m0 = model_reset(1'b0);
                m1 = model_reset(1'b1);
            end
            e.e0 = model_out(m0, i);
            e.e1 = model_out(m1, i);
            q.push_back(e);
            m0 = model_next(m0, i, 1'b0);
            m1 = model_next(m1, i, 1'b1);
        end
    endtask

    task automatic monitor();
        exp_t e;
        out_t a0, a1;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            #2;
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty cycle %0d: queue size 0, required >0", c);
            end else begin
                e  = q.pop_front();
                a0 = {phase0, inc0, ldpc0, lda0, ldf0, alu0, misc0, run0, bph0, cnt0};
                a1 = {phase1, inc1, ldpc1, lda1, ldf1, alu1, misc1, run1, bph1, cnt1};
                if (a0 !== e.e0) begin
                    miscompares++;
                    $display("FAIL dut_halt_start cycle %0d: got %h required %h", c, a0, e.e0);
                end
                vectors++;
                if (a1 !== e.e1) begin
                    miscompares++;
                    $display("FAIL dut_run_start cycle %0d: got %h required %h", c, a1, e.e1);
                end
            end
        end
    endtask

    initial begin
        apply('{rst_n: 1'b0, default: '0});
        fork
            stimulus();
            monitor();
        join
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #(NCYC * 10 + 1000);
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1);
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Run-control sequencer for the nibble core. Owns the fetch/execute phase and gates the decode micro-ROM strobes into PC, A, Flags and the misc control field.
- Adds run, halt and single-step control from a debug host, plus one PC breakpoint.
- Replaces the free-running phase flop. Sits between decode and the datapath registers.

Parameters:
- ADDR_W, 12, PC width.
- MISC_W, 6, width of the decode misc control field.
- MISC_WR_MASK, 6'b000011, misc bits that are write strobes and are forced 0 when not executing.
- START_RUN, 0, 1 = leave reset in RUN; 0 = leave reset in HALT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- run_req  in  1  pulse: resume execution
- halt_req  in  1  pulse: stop at next instruction boundary
- step_req  in  1  pulse: execute exactly one instruction from HALT
- bp_en  in  1  breakpoint enable
- bp_addr  in  ADDR_W  breakpoint PC
- pc  in  ADDR_W  current PC
- dec_incPC, dec_loadPC, dec_loadA, dec_loadFlags  in  1 each  raw decode strobes
- dec_aluopcode  in  3  raw ALU opcode
- dec_misc  in  MISC_W  raw misc control field
- phase  out  1  1 = fetch cycle, 0 = execute cycle; feeds decode and the Fetch enable
- incPC, loadPC, loadA, loadFlags  out  1 each  gated strobes
- aluopcode  out  3  pass-through of dec_aluopcode, never gated
- misc  out  MISC_W  dec_misc with MISC_WR_MASK bits gated
- running  out  1  state is RUN or STEP
- bp_hit  out  1  sticky; set on breakpoint halt
- instr_count  out  16  retired instruction count

Behaviour:
- Reset (reset=0, asynchronous):
  - state = RUN if START_RUN else HALT
  - phase=1, bp_hit=0, instr_count=0, skip_bp=0
  - all gated strobes 0
- States:
  - HALT: phase holds 1; gated strobes 0.
  - RUN: phase toggles every clk.
  - STEP: phase toggles every clk; returns to HALT after one instruction.
- Instruction: one fetch cycle (phase=1) followed by one execute cycle (phase=0). The boundary is the rising edge that ends an execute cycle.
- Gating: while state is RUN or STEP and the breakpoint is not firing this cycle, outputs = dec_* inputs. Otherwise incPC, loadPC, loadA, loadFlags and the masked misc bits are 0.
- Breakpoint:
  - Fires when bp_en=1, pc==bp_addr, phase=1, state=RUN and skip_bp=0.
  - Effect: that fetch is suppressed (strobes 0); next state HALT; bp_hit=1.
- skip_bp:
  - Set on any transition HALT->RUN or HALT->STEP.
  - Cleared at the first fetch cycle thereafter, so resuming at the breakpoint address does not re-trap.
- HALT->RUN on run_req. bp_hit clears on this transition.
- HALT->STEP on step_req. One instruction, breakpoint ignored, then HALT on the boundary edge. bp_hit unchanged.
- RUN->HALT on halt_req:
  - Pending flag is set; halt occurs at the next boundary edge.
  - If halt_req arrives during a fetch cycle, that instruction completes first.
  - Never stops mid-instruction.
- Simultaneous requests: halt_req > step_req > run_req.
  - run_req while in RUN is ignored; step_req while in RUN or STEP is ignored.
  - halt_req while in STEP cancels nothing; the step completes, then HALT.
- instr_count increments on every boundary edge in RUN or STEP, and wraps from 0xFFFF to 0.
- Reset mid-instruction aborts immediately. Nothing completes; all outputs go to reset values.

Optional Feature:
- INSTR_COUNT_EN
  - Defined: 16-bit counter implemented as above.
  - Undefined: counter logic omitted; instr_count tied to 16'h0000.

Test Plan:
- START_RUN=1, release reset with pc stepping through 0..3 → phase sequence 1,0,1,0; strobes equal dec_* in every cycle; instr_count=2 after 4 clk.
- halt_req pulsed in fetch cycle of the instruction at pc=5 → that instruction's execute strobes still occur; then phase stuck at 1, strobes 0, running=0, instr_count frozen.
- START_RUN=0; step_req pulsed three times, 10 clk apart → exactly 3 instructions execute, each lasting 2 cycles; instr_count=3; running high for exactly 2 cycles per step.
- bp_en=1, bp_addr=12'h00A, run → halt when pc=0x00A in fetch with incPC=0 and bp_hit=1; then run_req → 0x00A executes without re-trap and bp_hit clears.
- halt_req, step_req and run_req asserted in the same cycle while in HALT → state stays HALT, no strobes; step_req alone next cycle → one instruction.
- reset asserted during execute with dec_loadA=1 → loadA drops to 0 asynchronously; after release, state matches START_RUN and instr_count=0; with INSTR_COUNT_EN undefined, instr_count reads 0 throughout.
